// File: rtl/leglite_pkg.sv
// Shared types and constants for the 16-bit LEGv8-subset core.
package leglite_pkg;
  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;
  localparam int PC_STEP = 2;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_CBZ  = 4'd7,
    OP_ADDI = 4'd8
  } opcode_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head is presented combinationally and reads as zero when empty.
module fetch_fifo
  import leglite_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry_t,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_flush,
  input  logic        i_push,
  input  logic        i_pop,
  input  T            i_wdata,
  output T            o_rdata,
  output logic [AW:0] o_count
);
  T              r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wptr] <= i_wdata;
  end

  // Flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = (r_count != '0) ? r_mem[r_rptr] : '0;
  assign o_count = r_count;
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC register, prefetch queue arbitration, branch redirect and misalign flag.
module instr_fetch_unit
  import leglite_pkg::*;
#(
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  localparam int               AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  output logic [ADDR_W-1:0]  iaddr,
  input  logic [INSTR_W-1:0] idata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               misalign
);
  logic [ADDR_W-1:0] r_pc;
  logic              r_misalign;
  logic              w_push, w_pop;
  logic [AW:0]       w_count;
  fetch_entry_t      w_head, w_wdata;

  assign w_pop   = instr_valid & instr_ready;
  // A pop frees a slot this cycle, so a full queue can still accept a fetch.
  assign w_push  = fetch_en & ~redirect_valid & ((w_count < (AW+1)'(DEPTH)) | w_pop);
  assign w_wdata = '{pc: r_pc, instr: idata};

  fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
    end else if (redirect_valid) begin
      r_pc       <= {redirect_pc[ADDR_W-1:1], 1'b0};
      r_misalign <= r_misalign | redirect_pc[0];
    end else if (w_push) begin
      r_pc       <= r_pc + ADDR_W'(PC_STEP);
    end
  end

  assign iaddr       = r_pc;
  assign instr_valid = (w_count != '0);
  assign instr       = w_head.instr;
  assign instr_pc    = w_head.pc;
  assign misalign    = r_misalign;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic against a queue-based model.
module tb_instr_fetch_unit;
  localparam int          DEPTH    = 2;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 0, rst_n = 0, fetch_en = 0, redirect_valid = 0, instr_ready = 0;
  logic [15:0] iaddr, idata, redirect_pc = 0, instr, instr_pc;
  logic        instr_valid, misalign;

  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .iaddr(iaddr), .idata(idata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Instruction memory: 3x5 multiply program, then an address-derived filler.
  function automatic logic [15:0] im_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h80FA;
      16'h0002: return 16'h0E3C;
      16'h0004: return 16'h7F90;
      16'h0006: return 16'h0A21;
      16'h0008: return 16'h7002;
      16'h000A: return 16'h0F7C;
      default:  return {a[7:0] ^ 8'h3C, a[15:8] ^ 8'hC3};
    endcase
  endfunction
  assign idata = im_word(iaddr);

  typedef struct { logic [15:0] pc; logic [15:0] w; } ent_t;
  ent_t        mq[$];
  logic [15:0] m_pc;
  logic        m_mis;
  int          passes = 0, checks = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s got=%h expected=%h", tag, got, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc  = RESET_PC;
    m_mis = 1'b0;
  endtask

  // One clock of the architectural rules, applied to the pre-edge inputs.
  task automatic model_edge();
    bit pop, room;
    pop  = (mq.size() != 0) && instr_ready;
    room = (mq.size() < DEPTH) || pop;
    if (redirect_valid) begin
      mq.delete();
      m_pc  = {redirect_pc[15:1], 1'b0};
      m_mis = m_mis | redirect_pc[0];
    end else begin
      if (pop) void'(mq.pop_front());
      if (fetch_en && room) begin
        mq.push_back('{pc: m_pc, w: im_word(m_pc)});
        m_pc = m_pc + 16'd2;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    bit v;
    v = (mq.size() != 0);
    chk({tag, ".valid"}, {15'd0, instr_valid}, {15'd0, v});
    chk({tag, ".instr"}, instr, v ? mq[0].w : 16'h0000);
    chk({tag, ".ipc"}, instr_pc, v ? mq[0].pc : 16'h0000);
    chk({tag, ".iaddr"}, iaddr, m_pc);
    chk({tag, ".mis"}, {15'd0, misalign}, {15'd0, m_mis});
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic set_in(input bit fe, input bit rdy, input bit rv, input logic [15:0] rp);
    fetch_en = fe; instr_ready = rdy; redirect_valid = rv; redirect_pc = rp;
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    model_reset();
    chk({tag, ".rvalid"}, {15'd0, instr_valid}, 16'd0);
    chk({tag, ".riaddr"}, iaddr, RESET_PC);
    compare_all(tag);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    model_reset();
    #12;
    compare_all("reset");
    chk("reset.iaddr", iaddr, RESET_PC);
    @(negedge clk);
    rst_n = 1;

    // 1: straight-line fetch of the program
    set_in(1, 1, 0, 0);
    tick("t1.c1"); chk("t1.pc0", instr_pc, 16'h0000); chk("t1.w0", instr, 16'h80FA);
    tick("t1.c2"); chk("t1.pc2", instr_pc, 16'h0002); chk("t1.w2", instr, 16'h0E3C);
    tick("t1.c3"); chk("t1.pc4", instr_pc, 16'h0004); chk("t1.w4", instr, 16'h7F90);

    // 2: backpressure from a fresh start
    async_reset("t2");
    set_in(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick("t2.stall");
    chk("t2.freeze", iaddr, 16'(2 * DEPTH));
    set_in(1, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      chk("t2.order", instr_pc, 16'(2 * i));
      tick("t2.drain");
    end

    // 3: redirect to pc 4 while queue holds pc 8,10
    async_reset("t3");
    set_in(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick("t3.fill");
    set_in(1, 1, 0, 0);
    tick("t3.pop0"); tick("t3.pop1"); tick("t3.pop2"); tick("t3.pop3");
    chk("t3.head8", instr_pc, 16'h0008);
    set_in(1, 1, 1, 16'h0004);
    tick("t3.redir");
    set_in(1, 1, 0, 0);
    tick("t3.n1"); chk("t3.tgt", instr_pc, 16'h0004); chk("t3.tgtw", instr, 16'h7F90);
    tick("t3.n2"); chk("t3.tgt6", instr_pc, 16'h0006);

    // 4: redirect with full queue and simultaneous pop
    set_in(1, 0, 0, 0);
    tick("t4.f1"); tick("t4.f2");
    set_in(1, 1, 1, 16'h0002);
    tick("t4.redir");
    chk("t4.empty", {15'd0, instr_valid}, 16'd0);
    set_in(1, 1, 0, 0);
    tick("t4.n1"); chk("t4.tgt", instr_pc, 16'h0002);

    // 5: wrap and misaligned target
    set_in(1, 1, 1, 16'hFFFE);
    tick("t5.redir");
    set_in(1, 1, 0, 0);
    tick("t5.n1"); chk("t5.fffe", instr_pc, 16'hFFFE);
    tick("t5.n2"); chk("t5.wrap", instr_pc, 16'h0000);
    set_in(1, 1, 1, 16'h0005);
    tick("t5.odd");
    chk("t5.pc4", iaddr, 16'h0004);
    chk("t5.mis", {15'd0, misalign}, 16'd1);
    set_in(1, 1, 1, 16'h0010);
    tick("t5.even");
    chk("t5.sticky", {15'd0, misalign}, 16'd1);

    // 6: async reset mid-stream, then test 1 again
    set_in(1, 1, 0, 0);
    tick("t6.run");
    async_reset("t6");
    tick("t6.c1"); chk("t6.w0", instr, 16'h80FA);
    tick("t6.c2"); chk("t6.w2", instr, 16'h0E3C);
    tick("t6.c3"); chk("t6.w4", instr, 16'h7F90);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
             $urandom_range(0, 9) == 0, 16'($urandom()));
      if ($urandom_range(0, 99) == 0) async_reset("rnd.rst");
      else tick("rnd");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
